regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 10 +
 rtl/rf_scoreboard.sv | 49 ++++
 rtl/regfile_sb.sv | 82 ++++++++
 tb/tb_regfile_sb.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned N_RD_DEF   = 2;
    localparam int unsigned N_WR       = 2;
    localparam int unsigned REG_ZERO   = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue sets, writeback clears, flush clears all.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_WR-1:0]          wr_en,
    input  logic [N_WR*ADDR_W-1:0]   wr_addr,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic                     iss_ready,
    output logic [(1<<ADDR_W)-1:0]   busy
);

    logic [(1<<ADDR_W)-1:0] busy_nxt;
    logic                   iss_acc;

    assign iss_ready = (iss_addr == ADDR_W'(REG_ZERO)) || !busy[iss_addr];
    assign iss_acc   = iss_valid && iss_ready && (iss_addr != ADDR_W'(REG_ZERO));

    // Priority low to high: writeback clear, issue set, flush; r0 never busy.
    always_comb begin
        busy_nxt = busy;
        for (int unsigned p = 0; p < N_WR; p++) begin
            if (wr_en[p]) begin
                busy_nxt[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (iss_acc) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        busy_nxt[ADDR_W'(REG_ZERO)] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with two write ports and an issue scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write data to reads.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned N_RD   = N_RD_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_busy,
    input  logic [N_WR-1:0]          wr_en,
    input  logic [N_WR*ADDR_W-1:0]   wr_addr,
    input  logic [N_WR*DATA_W-1:0]   wr_data,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    input  logic                     flush
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    // Later port in the loop wins on an address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < N_WR; p++) begin
                if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO))) begin
                    mem[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .flush     (flush),
        .iss_ready (iss_ready),
        .busy      (busy)
    );

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rv = mem[ra];
`ifdef REGFILE_SB_BYPASS_EN
            for (int unsigned p = 0; p < N_WR; p++) begin
                if (rst && wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ra)) begin
                    rv = wr_data[p*DATA_W +: DATA_W];
                end
            end
`endif
            if (ra == ADDR_W'(REG_ZERO)) begin
                rv = '0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = rv;
        assign rd_busy[k]                  = busy[ra];
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        iss_ready;
    logic        flush;

    int checks;
    int errors;

    logic [31:0] m_reg [32];
    bit          m_busy [32];

    regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .flush     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic [31:0] v;
        if (!rst || a == 5'd0) return 32'h0;
        v = m_reg[a];
`ifdef REGFILE_SB_BYPASS_EN
        if (wr_en[0] && wr_addr[4:0] == a) v = wr_data[31:0];
        if (wr_en[1] && wr_addr[9:5] == a) v = wr_data[63:32];
`endif
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Apply the architectural effect of the current inputs, then cross one edge.
    task automatic tick();
        bit          acc;
        logic [4:0]  ia;
        if (rst) begin
            ia  = iss_addr;
            acc = iss_valid && ia != 5'd0 && !m_busy[ia];
            if (wr_en[0]) begin
                if (wr_addr[4:0] != 5'd0) m_reg[wr_addr[4:0]] = wr_data[31:0];
                m_busy[wr_addr[4:0]] = 1'b0;
            end
            if (wr_en[1]) begin
                if (wr_addr[9:5] != 5'd0) m_reg[wr_addr[9:5]] = wr_data[63:32];
                m_busy[wr_addr[9:5]] = 1'b0;
            end
            if (acc) m_busy[ia] = 1'b1;
            if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en     = 2'b00;
        wr_addr   = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        flush     = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p]          = 1'b1;
        wr_addr[p*5 +: 5]  = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic test_reset();
        model_clear();
        idle();
        rd_addr = {5'd7, 5'd5};
        #2 rst = 1'b0;
        set_wr(0, 5'd5, 32'hCAFE0005);
        set_wr(1, 5'd7, 32'hCAFE0007);
        iss_valid = 1'b1;
        iss_addr  = 5'd9;
        tick();
        tick();
        checks++;
        if (rd_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_rd_data got %h exp 0", rd_data);
        end
        checks++;
        if (rd_busy !== 2'b00 || iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy got busy=%b ready=%b exp busy=00 ready=1", rd_busy, iss_ready);
        end
        #2 rst = 1'b1;
        idle();
        tick();
        #1;
        checks++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL reset_release got data=%h busy=%b exp 0", rd_data, rd_busy);
        end
    endtask

    task automatic test_write_read();
        idle();
        set_wr(0, 5'd5, 32'hDEADBEEF);
        tick();
        idle();
        rd_addr = {5'd0, 5'd5};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL write_r5 got %h busy=%b exp deadbeef busy=0", rd_data[31:0], rd_busy[0]);
        end
    endtask

    task automatic test_r0();
        idle();
        set_wr(0, 5'd0, 32'h12345678);
        tick();
        idle();
        rd_addr   = {5'd0, 5'd0};
        iss_valid = 1'b1;
        iss_addr  = 5'd0;
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0 || iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL r0_write got %h ready=%b exp 0 ready=1", rd_data[31:0], iss_ready);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL r0_busy got %b exp 0", rd_busy[0]);
        end
    endtask

    task automatic test_same_addr();
        idle();
        set_wr(0, 5'd7, 32'h1);
        set_wr(1, 5'd7, 32'h2);
        tick();
        idle();
        rd_addr = {5'd7, 5'd7};
        #1;
        checks++;
        if (rd_data !== {32'h2, 32'h2}) begin
            errors++;
            $display("FAIL port1_wins got %h exp 0000000200000002", rd_data);
        end
    endtask

    task automatic test_issue();
        idle();
        iss_valid = 1'b1;
        iss_addr  = 5'd3;
        tick();
        rd_addr = {5'd0, 5'd3};
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || iss_ready !== 1'b0) begin
            errors++;
            $display("FAIL issue_r3 got busy=%b ready=%b exp busy=1 ready=0", rd_busy[0], iss_ready);
        end
        tick();
        idle();
        set_wr(1, 5'd3, 32'hA5);
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL busy_no_bypass got %b exp 1", rd_busy[0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'hA5) begin
            errors++;
            $display("FAIL wb_r3 got busy=%b data=%h exp busy=0 data=a5", rd_busy[0], rd_data[31:0]);
        end
    endtask

    task automatic test_wb_issue_flush();
        idle();
        set_wr(0, 5'd9, 32'h99);
        iss_valid = 1'b1;
        iss_addr  = 5'd9;
        tick();
        idle();
        rd_addr = {5'd9, 5'd9};
        #1;
        checks++;
        if (rd_busy !== 2'b11 || rd_data[63:32] !== 32'h99) begin
            errors++;
            $display("FAIL issue_beats_wb got busy=%b data=%h exp busy=11 data=99", rd_busy, rd_data[63:32]);
        end
        iss_valid = 1'b1;
        iss_addr  = 5'd11;
        flush     = 1'b1;
        set_wr(1, 5'd12, 32'h1212);
        tick();
        idle();
        rd_addr = {5'd11, 5'd9};
        #1;
        checks++;
        if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'h99) begin
            errors++;
            $display("FAIL flush got busy=%b data=%h exp busy=00 data=99", rd_busy, rd_data[31:0]);
        end
        rd_addr = {5'd12, 5'd12};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h1212) begin
            errors++;
            $display("FAIL flush_keeps_write got %h exp 1212", rd_data[31:0]);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_now;
        idle();
        set_wr(0, 5'd4, 32'h11);
        tick();
        idle();
        set_wr(1, 5'd4, 32'h55);
        rd_addr = {5'd0, 5'd4};
`ifdef REGFILE_SB_BYPASS_EN
        exp_now = 32'h55;
`else
        exp_now = 32'h11;
`endif
        #1;
        checks++;
        if (rd_data[31:0] !== exp_now) begin
            errors++;
            $display("FAIL bypass_same_cycle got %h exp %h", rd_data[31:0], exp_now);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h55) begin
            errors++;
            $display("FAIL bypass_next_cycle got %h exp 55", rd_data[31:0]);
        end
        set_wr(0, 5'd4, 32'h77);
        iss_valid = 1'b1;
        iss_addr  = 5'd6;
        rd_addr   = {5'd9, 5'd4};
        #2 rst = 1'b0;
        model_clear();
        #1;
        checks++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00 || iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got data=%h busy=%b ready=%b exp 0/00/1", rd_data, rd_busy, iss_ready);
        end
        tick();
        #2 rst = 1'b1;
        idle();
        tick();
        rd_addr  = {5'd6, 5'd4};
        iss_addr = 5'd6;
        #1;
        checks++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00 || iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_reset got data=%h busy=%b ready=%b exp 0/00/1", rd_data, rd_busy, iss_ready);
        end
    endtask

    task automatic test_random();
        logic [4:0]  a0, a1;
        logic [31:0] e0, e1;
        bit          er;
        for (int c = 0; c < 500; c++) begin
            idle();
            if ($urandom_range(0, 2) == 0) set_wr(0, 5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 2) == 0) set_wr(1, 5'($urandom_range(0, 7)), $urandom);
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_addr  = 5'($urandom_range(0, 9));
            flush     = ($urandom_range(0, 19) == 0);
            a0 = 5'($urandom_range(0, 9));
            a1 = 5'($urandom_range(0, 31));
            rd_addr = {a1, a0};
            #1;
            e0 = exp_rd(a0);
            e1 = exp_rd(a1);
            er = (iss_addr == 5'd0) || !m_busy[iss_addr];
            checks++;
            if (rd_data !== {e1, e0}) begin
                errors++;
                $display("FAIL rand_data cyc %0d got %h exp %h", c, rd_data, {e1, e0});
            end
            checks++;
            if (rd_busy !== {m_busy[a1], m_busy[a0]} || iss_ready !== er) begin
                errors++;
                $display("FAIL rand_busy cyc %0d got busy=%b ready=%b exp busy=%b%b ready=%b",
                         c, rd_busy, iss_ready, m_busy[a1], m_busy[a0], er);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        rd_addr   = '0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        flush     = 1'b0;
        test_reset();
        test_write_read();
        test_r0();
        test_same_addr();
        test_issue();
        test_wb_issue_flush();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
